// File: rtl/noc_vc_link_arbiter_pkg.sv
// Shared NoC link-arbiter definitions: default sizes, flit type bit positions,
// credit counter type and packet-lock state encoding.
package noc_vc_link_arbiter_pkg;

    localparam int unsigned Noc_VC_Channel    = 4;
    localparam int unsigned Noc_Flit_Width    = 32;
    localparam int unsigned Noc_Flit_Head_Bit = 1;
    localparam int unsigned Noc_Flit_Tail_Bit = 0;
    localparam int unsigned Noc_Credit_Max    = 8;

    typedef logic [$clog2(Noc_Credit_Max + 1)-1:0] noc_credit_t;

    typedef enum logic {
        IDLE,
        LOCKED
    } lock_state_e;

endpackage

// File: rtl/noc_vc_link_arbiter_if.sv
// Per-VC FIFO side and physical link side of the VC link arbiter.
interface noc_vc_link_arbiter_if
    import noc_vc_link_arbiter_pkg::*;
#(
    parameter int unsigned CHANNELS   = Noc_VC_Channel,
    parameter int unsigned FLIT_WIDTH = Noc_Flit_Width
) ();

    logic [CHANNELS-1:0]            i_valid;
    logic [CHANNELS*FLIT_WIDTH-1:0] i_flit;
    logic [CHANNELS-1:0]            o_ready;
    logic [CHANNELS-1:0]            o_valid;
    logic [FLIT_WIDTH-1:0]          o_flit;
    logic [CHANNELS-1:0]            i_credit_return;
    logic [CHANNELS-1:0]            o_credit_avail;

    modport master (
        output i_valid, i_flit, i_credit_return,
        input  o_ready, o_valid, o_flit, o_credit_avail
    );

    modport slave (
        input  i_valid, i_flit, i_credit_return,
        output o_ready, o_valid, o_flit, o_credit_avail
    );

endinterface

// File: rtl/noc_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, priority starts after the last granted
// requester; pointer moves only when i_advance is high.
module noc_rr_arbiter #(
    parameter int unsigned N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic [N-1:0] req,
    input  logic         i_advance,
    output logic [N-1:0] gnt
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW:0]   idx;
    logic          found;

    always_comb begin
        gnt   = '0;
        ptr_d = ptr_q;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = {1'b0, ptr_q} + (PW+1)'(i);
            if (idx >= (PW+1)'(N)) idx = idx - (PW+1)'(N);
            if (!found && req[idx[PW-1:0]]) begin
                found               = 1'b1;
                gnt[idx[PW-1:0]]    = 1'b1;
                ptr_d               = (idx[PW-1:0] == PW'(N - 1)) ? '0 : idx[PW-1:0] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         ptr_q <= '0;
        else if (clear)     ptr_q <= '0;
        else if (i_advance) ptr_q <= ptr_d;
    end

endmodule

// File: rtl/noc_vc_link_arbiter.sv
// Router output-port VC arbiter: round-robin pop of per-VC FIFOs onto one link,
// per-VC credit counters. Define NOC_PACKET_LOCK_EN to hold the link per packet.
module noc_vc_link_arbiter
    import noc_vc_link_arbiter_pkg::*;
#(
    parameter int unsigned CHANNELS   = Noc_VC_Channel,
    parameter int unsigned FLIT_WIDTH = Noc_Flit_Width,
    parameter int unsigned CREDITS    = 8
) (
    input  logic                  noc_clk,
    input  logic                  noc_rst_n,
    input  logic                  i_clear,
    noc_vc_link_arbiter_if.slave  link
);

    localparam int unsigned CW = $clog2(CREDITS + 1);
    localparam int unsigned VW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS-1:0]   credit_nz;
    logic [CHANNELS-1:0]   req;
    logic [CHANNELS-1:0]   arb_req;
    logic [CHANNELS-1:0]   grant;
    logic [FLIT_WIDTH-1:0] grant_flit;

    assign req                 = link.i_valid & credit_nz;
    assign link.o_ready        = grant;
    assign link.o_credit_avail = credit_nz;

    noc_rr_arbiter #(.N(CHANNELS)) u_rr (
        .clk       (noc_clk),
        .rst_n     (noc_rst_n),
        .clear     (i_clear),
        .req       (arb_req),
        .i_advance (|grant),
        .gnt       (grant)
    );

    always_comb begin
        grant_flit = '0;
        for (int unsigned v = 0; v < CHANNELS; v++) begin
            if (grant[v]) grant_flit = link.i_flit[v*FLIT_WIDTH +: FLIT_WIDTH];
        end
    end

    for (genvar v = 0; v < CHANNELS; v++) begin : g_credit
        logic [CW-1:0] credit_q;

        // Grant and return together cancel; a return at full credit saturates.
        always_ff @(posedge noc_clk or negedge noc_rst_n) begin
            if (!noc_rst_n)
                credit_q <= CW'(CREDITS);
            else if (i_clear)
                credit_q <= CW'(CREDITS);
            else if (grant[v] && !link.i_credit_return[v])
                credit_q <= credit_q - 1'b1;
            else if (!grant[v] && link.i_credit_return[v] && credit_q != CW'(CREDITS))
                credit_q <= credit_q + 1'b1;
        end

        assign credit_nz[v] = (credit_q != '0);

        a_credit_overflow : assert property (@(posedge noc_clk) disable iff (!noc_rst_n || i_clear)
            !(link.i_credit_return[v] && credit_q == CW'(CREDITS)));
    end

`ifdef NOC_PACKET_LOCK_EN
    lock_state_e   state_q;
    lock_state_e   state_d;
    logic [VW-1:0] lock_vc_q;
    logic [VW-1:0] lock_vc_d;
    logic [VW-1:0] grant_vc;

    always_comb begin
        grant_vc = '0;
        for (int unsigned v = 0; v < CHANNELS; v++) begin
            if (grant[v]) grant_vc = VW'(v);
        end
    end

    always_comb begin
        arb_req = req;
        if (state_q == LOCKED) begin
            arb_req            = '0;
            arb_req[lock_vc_q] = req[lock_vc_q];
        end
    end

    always_comb begin
        state_d   = state_q;
        lock_vc_d = lock_vc_q;
        case (state_q)
            IDLE: begin
                if (|grant && grant_flit[Noc_Flit_Head_Bit] && !grant_flit[Noc_Flit_Tail_Bit]) begin
                    state_d   = LOCKED;
                    lock_vc_d = grant_vc;
                end
            end
            LOCKED: begin
                if (|grant && grant_flit[Noc_Flit_Tail_Bit]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            state_q   <= IDLE;
            lock_vc_q <= '0;
        end else if (i_clear) begin
            state_q   <= IDLE;
            lock_vc_q <= '0;
        end else begin
            state_q   <= state_d;
            lock_vc_q <= lock_vc_d;
        end
    end
`else
    assign arb_req = req;
`endif

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            link.o_valid <= '0;
            link.o_flit  <= '0;
        end else if (i_clear) begin
            link.o_valid <= '0;
            link.o_flit  <= '0;
        end else begin
            link.o_valid <= grant;
            if (|grant) link.o_flit <= grant_flit;
        end
    end

endmodule

// File: tb/tb_noc_vc_link_arbiter.sv
// Directed bench for noc_vc_link_arbiter with CHANNELS=2, FLIT_WIDTH=8, CREDITS=4.
module tb_noc_vc_link_arbiter;

    logic       noc_clk = 1'b0;
    logic       noc_rst_n;
    logic       i_clear;
    int         errors = 0;
    int         checks = 0;
    int         pops;
    int         idx;
    logic [7:0] pkt [4];
    logic [1:0] exp_rdy [8];

    noc_vc_link_arbiter_if #(.CHANNELS(2), .FLIT_WIDTH(8)) link ();

    noc_vc_link_arbiter #(.CHANNELS(2), .FLIT_WIDTH(8), .CREDITS(4)) dut (
        .noc_clk   (noc_clk),
        .noc_rst_n (noc_rst_n),
        .i_clear   (i_clear),
        .link      (link)
    );

    always #5 noc_clk = ~noc_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge noc_clk);
        @(negedge noc_clk);
    endtask

    initial begin
        noc_rst_n            = 1'b0;
        i_clear              = 1'b0;
        link.i_valid         = '0;
        link.i_flit          = '0;
        link.i_credit_return = '0;
        pkt = '{8'h52, 8'h60, 8'h64, 8'h71};
`ifdef NOC_PACKET_LOCK_EN
        exp_rdy = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10};
`else
        exp_rdy = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
`endif

        repeat (2) @(negedge noc_clk);
        noc_rst_n = 1'b1;
        #1;
        chk("reset_o_valid", link.o_valid, 2'b00);
        chk("reset_o_ready", link.o_ready, 2'b00);
        chk("reset_credit_avail", link.o_credit_avail, 2'b11);
        chk("reset_o_flit", link.o_flit, 8'h00);
        step();
        #1 chk("idle_o_valid", link.o_valid, 2'b00);

        // VC0 alone, 4 credits: four pops then starved
        link.i_valid = 2'b01;
        pops = 0;
        for (int k = 0; k < 6; k++) begin
            link.i_flit = {8'hC3, 8'(16 + k)};
            #1;
            chk("t2_o_ready", link.o_ready, (k < 4) ? 2'b01 : 2'b00);
            chk("t2_o_valid", link.o_valid, (k >= 1 && k <= 4) ? 2'b01 : 2'b00);
            if (k >= 1 && k <= 4) chk("t2_o_flit", link.o_flit, 8'(16 + k - 1));
            if (link.o_ready[0]) pops++;
            step();
        end
        #1;
        chk("t2_pop_count", pops, 4);
        chk("t2_credit_avail", link.o_credit_avail, 2'b10);
        chk("t2_o_valid_idle", link.o_valid, 2'b00);
        chk("t2_o_flit_hold", link.o_flit, 8'h13);
        link.i_credit_return = 2'b01;
        #1 chk("t2_return_cycle_ready", link.o_ready, 2'b00);
        step();
        link.i_credit_return = 2'b00;
        #1 chk("t2_repop_ready", link.o_ready, 2'b01);
        step();
        #1 chk("t2_repop_valid", link.o_valid, 2'b01);

        // drain VC1 so the credit-return phase cannot overflow
        link.i_valid = 2'b10;
        for (int k = 0; k < 4; k++) begin
            #1 chk("t3_drain_vc1", link.o_ready, 2'b10);
            step();
        end

        // both VCs valid, returns every cycle: alternate grants
        link.i_valid         = 2'b11;
        link.i_credit_return = 2'b11;
        link.i_flit          = {8'hB3, 8'hA3};
        #1;
        chk("t3_no_credit_ready", link.o_ready, 2'b00);
        chk("t3_no_credit_avail", link.o_credit_avail, 2'b00);
        step();
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t3_o_ready", link.o_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            if (k > 0) chk("t3_o_flit", link.o_flit, (k % 2 == 1) ? 8'hA3 : 8'hB3);
            step();
        end
        link.i_credit_return = 2'b00;
        link.i_valid         = 2'b01;
        #1;
        chk("t3_last_o_flit", link.o_flit, 8'hB3);
        chk("t3_last_o_valid", link.o_valid, 2'b10);
        chk("t3_credit_avail", link.o_credit_avail, 2'b11);

        // VC0 credits 3 -> 1, then grant and return together
        chk("t4_drain_ready", link.o_ready, 2'b01);
        step();
        #1 chk("t4_drain_ready", link.o_ready, 2'b01);
        step();
        link.i_credit_return = 2'b01;
        #1 chk("t4_grant_and_return", link.o_ready, 2'b01);
        step();
        link.i_credit_return = 2'b00;
        #1;
        chk("t4_credit_avail_kept", link.o_credit_avail, 2'b11);
        chk("t4_last_pop", link.o_ready, 2'b01);
        step();
        #1;
        chk("t4_credit_exhausted", link.o_ready, 2'b00);
        chk("t4_avail_after", link.o_credit_avail, 2'b10);

        // bring VC1 to 1 credit and leave the pointer at VC1
        link.i_valid         = 2'b10;
        link.i_credit_return = 2'b01;
        #1 chk("t6_setup_vc1_a", link.o_ready, 2'b10);
        step();
        link.i_credit_return = 2'b00;
        #1 chk("t6_setup_vc1_b", link.o_ready, 2'b10);
        step();
        link.i_valid = 2'b01;
        #1 chk("t6_setup_vc0", link.o_ready, 2'b01);
        step();
        link.i_valid = 2'b10;
        #1 chk("t6_pre_clear_avail", link.o_credit_avail, 2'b10);
        i_clear = 1'b1;
        step();
        i_clear      = 1'b0;
        link.i_valid = 2'b00;
        #1;
        chk("t6_clear_o_valid", link.o_valid, 2'b00);
        chk("t6_clear_credit_avail", link.o_credit_avail, 2'b11);

        // VC0 packet head/body/body/tail with VC1 always valid
        idx = 0;
        for (int k = 0; k < 8; k++) begin
            link.i_valid = {1'b1, (idx < 4)};
            link.i_flit  = {8'hC3, pkt[idx[1:0]]};
            #1;
            chk("t5_o_ready", link.o_ready, exp_rdy[k]);
            if (k > 0) chk("t5_o_valid", link.o_valid, exp_rdy[k-1]);
            if (k == 1) chk("t5_head_flit", link.o_flit, 8'h52);
            if (link.o_ready[0]) idx++;
            step();
        end
        link.i_valid = 2'b00;
        #1;
        chk("t5_final_o_valid", link.o_valid, 2'b10);
        chk("t5_final_credit_avail", link.o_credit_avail, 2'b00);
        chk("t5_vc0_flits_sent", idx, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
